usb_tx_encoder: RTL

Bit-level line encoder for the USB full-speed transmit path; sits directly downstream of the transmit control FSM and its parallel-to-serial shifter. Consumes one serialized data bit per bit period. Applies bit stuffing after `STUFF_LIMIT` consecutive ones and NRZI-encodes the result onto `dplus`/`dminus`. Generates the SE0-SE0-J end-of-packet sequence on request. Reports stuff-bit insertion back upstream so the shifter and control FSM stall for one bit period.

---
 rtl/usb_tx_encoder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit line encoder: bit stuffing, NRZI encoding onto
// dplus/dminus, and SE0-SE0-J end-of-packet generation. Line changes only on
// bit_strobe cycles; stuffing tells upstream to hold its shifter for one bit.
module usb_tx_encoder #(
  parameter int unsigned STUFF_LIMIT = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic bit_strobe,
  input  logic tx_active,
  input  logic serial_in,
  input  logic eop,
  output logic stuffing,
  output logic dplus,
  output logic dminus,
  output logic busy,
  output logic eop_done
);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    SE0_1,
    SE0_2,
    EOP_J
  } state_t;

  localparam logic [2:0] LIMIT = 3'(STUFF_LIMIT);

  state_t     state, state_next;
  logic       level, level_next;
  logic [2:0] ones_cnt, ones_cnt_next;
  logic       eop_pend, eop_pend_next;
  logic       dplus_next, dminus_next;
  logic       eop_done_next;
  logic       eop_req;

  // An eop arriving on a strobe cycle counts as already pending for that strobe
  assign eop_req = eop_pend | (eop & (state != IDLE));

  // A stuff bit is owed whenever the run of ones has reached the limit in DATA
  assign stuffing = (state == DATA) && (ones_cnt == LIMIT);

  // Next-state, line level and counter decisions, evaluated per bit strobe
  always_comb begin
    state_next    = state;
    level_next    = level;
    ones_cnt_next = ones_cnt;
    eop_pend_next = eop_req;
    dplus_next    = dplus;
    dminus_next   = dminus;
    eop_done_next = 1'b0;

    case (state)
      IDLE: begin
        eop_pend_next = 1'b0;
        dplus_next    = 1'b1;
        dminus_next   = 1'b0;
        level_next    = 1'b1;
        ones_cnt_next = 3'd0;
        if (tx_active) begin
          state_next = DATA;
        end
      end

      DATA: begin
        if (bit_strobe) begin
          if (ones_cnt == LIMIT) begin
            level_next    = ~level;
            ones_cnt_next = 3'd0;
            dplus_next    = ~level;
            dminus_next   = level;
          end else if (eop_req) begin
            state_next  = SE0_1;
            dplus_next  = 1'b0;
            dminus_next = 1'b0;
          end else if (!tx_active) begin
            state_next    = IDLE;
            level_next    = 1'b1;
            ones_cnt_next = 3'd0;
            eop_pend_next = 1'b0;
            dplus_next    = 1'b1;
            dminus_next   = 1'b0;
          end else if (!serial_in) begin
            level_next    = ~level;
            ones_cnt_next = 3'd0;
            dplus_next    = ~level;
            dminus_next   = level;
          end else begin
            if (ones_cnt < LIMIT) begin
              ones_cnt_next = ones_cnt + 3'd1;
            end
            dplus_next  = level;
            dminus_next = ~level;
          end
        end
      end

      SE0_1: begin
        if (bit_strobe) begin
          state_next  = SE0_2;
          dplus_next  = 1'b0;
          dminus_next = 1'b0;
        end
      end

      SE0_2: begin
        if (bit_strobe) begin
          state_next  = EOP_J;
          dplus_next  = 1'b1;
          dminus_next = 1'b0;
        end
      end

      EOP_J: begin
        if (bit_strobe) begin
          state_next    = IDLE;
          eop_done_next = 1'b1;
          eop_pend_next = 1'b0;
          ones_cnt_next = 3'd0;
          level_next    = 1'b1;
          dplus_next    = 1'b1;
          dminus_next   = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counters and registered line outputs; reset forces the line to J
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      level    <= 1'b1;
      ones_cnt <= 3'd0;
      eop_pend <= 1'b0;
      dplus    <= 1'b1;
      dminus   <= 1'b0;
      busy     <= 1'b0;
      eop_done <= 1'b0;
    end else begin
      state    <= state_next;
      level    <= level_next;
      ones_cnt <= ones_cnt_next;
      eop_pend <= eop_pend_next;
      dplus    <= dplus_next;
      dminus   <= dminus_next;
      busy     <= (state_next != IDLE);
      eop_done <= eop_done_next;
    end
  end

endmodule
